axi_sram_slave: RTL and testbench
=================================

# axi_sram_slave

AXI4 responder (slave end) that serves a single-port synchronous SRAM of 16K × 32-bit words behind the bus bridge's slave-side ports. It accepts one transaction at a time, either a write burst (AW/W/B) or a read burst (AR/R), and maps each burst onto back-to-back SRAM word accesses. It is the counterpart of the master-side interface: it samples the bridge's AW/W/AR/B-ready/R-ready outputs and drives the response channels.

## Interface
Parameters:
- IDW, 8: slave-side ID width (master ID plus bridge master tag).
- SRAM_AW, 14: SRAM word-address width.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  IDW/32/4/3/2/1  write address.
- AWREADY  out  1.
- WDATA/WSTRB/WLAST/WVALID  in  32/4/1/1  write data.
- WREADY  out  1.
- BID/BRESP/BVALID  out  IDW/2/1  write response.
- BREADY  in  1.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  IDW/32/4/3/2/1  read address.
- ARREADY  out  1.
- RID/RDATA/RRESP/RLAST/RVALID  out  IDW/32/2/1/1  read data.
- RREADY  in  1.
- sram_cs  out  1  chip select, active-high.
- sram_oe  out  1  output enable, active-high.
- sram_web  out  4  per-byte write enable, active-low.
- sram_a  out  SRAM_AW  word address.
- sram_di  out  32  write data.
- sram_do  in  32  read data, valid the cycle after the address is sampled.

## Operation
- FSM states: IDLE, WRITE, BRESP, READ.
- IDLE: AWREADY=1. ARREADY=!AWVALID, so a write wins when both channels are valid in the same cycle.
- AW handshake: latch ID, word address = AWADDR[15:2], and AWLEN. Go to WRITE.
- AR handshake: latch ID, word address = ARADDR[15:2], and ARLEN. Clear the beat counter. Go to READ.
- WRITE:
  - WREADY=1.
  - Each W handshake drives sram_cs=1, sram_web=~WSTRB, sram_a=current address, sram_di=WDATA.
  - The address then increments by 1, modulo 2^SRAM_AW (16383 wraps to 0).
  - The beat counter increments on every beat.
  - A handshake with WLAST=1 moves to BRESP.
- BRESP:
  - BVALID=1, BID=latched ID.
  - BRESP=OKAY (2'b00), or SLVERR (2'b10) per Configuration.
  - The BVALID&BREADY handshake returns to IDLE.
- READ:
  - RVALID=1 from the cycle after the AR handshake.
  - RDATA=sram_do, RID=latched ID, RRESP=OKAY.
  - RLAST=(beat counter == latched LEN).
  - sram_cs=sram_oe=1.
  - sram_a = address+1 when RVALID&RREADY, else address. RDATA therefore stays stable while the master stalls.
  - The handshake with RLAST=1 returns to IDLE.
- AWSIZE/ARSIZE are ignored; every beat is 4 bytes. Bursts are INCR.
- Outside the active access cycles: sram_web=4'hF, sram_cs=0, sram_oe=0.

## Timing
- While rst=1, all outputs are 0 (sram_web=4'hF). On the first cycle after rst deasserts, the state is IDLE.
- AR handshake at cycle t:
  - sram_a carries the first address during t.
  - First RVALID at t+1.
  - Beats are back-to-back with no bubbles while RREADY=1.
  - An N-beat read with RREADY held high completes its last handshake at t+N.
- AW handshake at t: WREADY=1 from t+1. Each beat writes in its own handshake cycle.
- WLAST handshake at t: BVALID=1 at t+1, held until BREADY.
- A new AW or AR is accepted no earlier than the cycle after the B or last-R handshake.
- No outstanding or overlapping transactions: ready stays low on the idle channel while busy.
- A reset asserted mid-burst aborts the burst with no response issued. SRAM contents already written are kept.

## Configuration
- AXI_SRAM_ERRCHK_EN defined:
  - BRESP/RRESP=SLVERR when the burst type ≠ INCR (2'b01).
  - For writes, also when the beat count at WLAST ≠ AWLEN+1.
  - Data transfer proceeds identically.
- Undefined: responses are always OKAY and no checking logic is generated.

## Test plan
- Reset, then idle: all outputs 0 during rst. After release AWREADY=1, ARREADY=1, and sram_cs=0.
- Write AWADDR=0x100, AWLEN=3, data 0xA0..0xA3, WSTRB=4'hF, with BREADY stalled 2 cycles. Required: SRAM words 0x40..0x43 written, BVALID held 3 cycles, BRESP=0, BID echoed.
- Read ARADDR=0x100, ARLEN=3, RREADY toggling 1/0. Required: RDATA 0xA0..0xA3 in order, stable during stalls, RLAST only on beat 4, first RVALID one cycle after AR.
- Partial strobe: write 0xFFFFFFFF to word 0x10, then WSTRB=4'b0101 with data 0x00000000, then read. Required: 0xFF00FF00.
- AWVALID and ARVALID asserted in the same cycle in IDLE: the AW handshake wins, ARREADY=0 until after the B handshake, then AR is accepted.
- With AXI_SRAM_ERRCHK_EN defined:
  - AWLEN=3 with WLAST on beat 2: BRESP=2'b10.
  - ARBURST=2'b00: RRESP=2'b10 on all beats.
- Boundary: a read at word 16383 with LEN=1 returns word 16383, then word 0.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// AXI4 slave-side bus bundle for axi_sram_slave: AW/W/B/AR/R channels.
// The master modport is used by whatever drives the requests (bridge or bench).
interface axi_sram_slave_if #(
  parameter int IDW = 8
) ();

  logic [IDW-1:0] AWID;
  logic [31:0]    AWADDR;
  logic [3:0]     AWLEN;
  logic [2:0]     AWSIZE;
  logic [1:0]     AWBURST;
  logic           AWVALID;
  logic           AWREADY;

  logic [31:0]    WDATA;
  logic [3:0]     WSTRB;
  logic           WLAST;
  logic           WVALID;
  logic           WREADY;

  logic [IDW-1:0] BID;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY;

  logic [IDW-1:0] ARID;
  logic [31:0]    ARADDR;
  logic [3:0]     ARLEN;
  logic [2:0]     ARSIZE;
  logic [1:0]     ARBURST;
  logic           ARVALID;
  logic           ARREADY;

  logic [IDW-1:0] RID;
  logic [31:0]    RDATA;
  logic [1:0]     RRESP;
  logic           RLAST;
  logic           RVALID;
  logic           RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 responder in front of a 16K x 32 single-port synchronous SRAM.
// One transaction at a time: write burst (AW/W/B) or read burst (AR/R),
// each beat mapped onto one SRAM word access, INCR addressing only.
// Optional response checking is compiled in with `define AXI_SRAM_ERRCHK_EN:
// SLVERR on non-INCR bursts and on write bursts whose beat count at WLAST
// disagrees with AWLEN+1. Without it every response is OKAY.
module axi_sram_slave #(
  parameter int IDW     = 8,
  parameter int SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  axi_sram_slave_if.slave    bus,
  output logic               sram_cs,
  output logic               sram_oe,
  output logic [3:0]         sram_web,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [31:0]        sram_di,
  input  logic [31:0]        sram_do
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_BRESP,
    S_READ
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [IDW-1:0]     id_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [3:0]         len_q;
  logic [4:0]         beat_q;
  logic [1:0]         resp;
  logic               rlast;
  logic               aw_hs;
  logic               w_hs;
  logic               ar_hs;
  logic               r_hs;
  logic               unused_bits;

  // Size is fixed at 4 bytes and only the SRAM word field of the address matters.
  assign unused_bits = ^{bus.AWADDR[31:SRAM_AW+2], bus.AWADDR[1:0],
                         bus.ARADDR[31:SRAM_AW+2], bus.ARADDR[1:0],
                         bus.AWSIZE, bus.ARSIZE, bus.AWBURST, bus.ARBURST};

`ifdef AXI_SRAM_ERRCHK_EN
  logic err_q;
  assign resp = err_q ? 2'b10 : 2'b00;
`else
  assign resp = 2'b00;
`endif

  assign rlast = (beat_q == {1'b0, len_q});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state, bus outputs and SRAM controls; everything is held at zero during reset.
  always_comb begin
    state_nx    = state;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    ar_hs       = 1'b0;
    r_hs        = 1'b0;
    bus.AWREADY = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BID     = '0;
    bus.BRESP   = 2'b00;
    bus.BVALID  = 1'b0;
    bus.ARREADY = 1'b0;
    bus.RID     = '0;
    bus.RDATA   = '0;
    bus.RRESP   = 2'b00;
    bus.RLAST   = 1'b0;
    bus.RVALID  = 1'b0;
    sram_cs     = 1'b0;
    sram_oe     = 1'b0;
    sram_web    = '1;
    sram_a      = addr_q;
    sram_di     = '0;
    if (!rst) begin
      unique case (state)
        S_IDLE: begin
          bus.AWREADY = 1'b1;
          bus.ARREADY = !bus.AWVALID;
          aw_hs       = bus.AWVALID;
          ar_hs       = bus.ARVALID && !bus.AWVALID;
          if (aw_hs) begin
            state_nx = S_WRITE;
          end else if (ar_hs) begin
            // Issue the first read now so its data is on sram_do when RVALID rises.
            state_nx = S_READ;
            sram_cs  = 1'b1;
            sram_oe  = 1'b1;
            sram_a   = bus.ARADDR[SRAM_AW+1:2];
          end
        end
        S_WRITE: begin
          bus.WREADY = 1'b1;
          w_hs       = bus.WVALID;
          if (w_hs) begin
            sram_cs  = 1'b1;
            sram_web = ~bus.WSTRB;
            sram_di  = bus.WDATA;
            if (bus.WLAST) state_nx = S_BRESP;
          end
        end
        S_BRESP: begin
          bus.BVALID = 1'b1;
          bus.BID    = id_q;
          bus.BRESP  = resp;
          if (bus.BREADY) state_nx = S_IDLE;
        end
        S_READ: begin
          bus.RVALID = 1'b1;
          bus.RID    = id_q;
          bus.RDATA  = sram_do;
          bus.RRESP  = resp;
          bus.RLAST  = rlast;
          sram_cs    = 1'b1;
          sram_oe    = 1'b1;
          r_hs       = bus.RREADY;
          // Prefetch the next word only on acceptance so RDATA holds during stalls.
          if (r_hs) begin
            sram_a = addr_q + 1'b1;
            if (rlast) state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Burst context: ID, word address, length, beat count (and error flag).
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      beat_q <= '0;
`ifdef AXI_SRAM_ERRCHK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      if (aw_hs) begin
        id_q   <= bus.AWID;
        addr_q <= bus.AWADDR[SRAM_AW+1:2];
        len_q  <= bus.AWLEN;
        beat_q <= '0;
`ifdef AXI_SRAM_ERRCHK_EN
        err_q  <= (bus.AWBURST != 2'b01);
`endif
      end else if (ar_hs) begin
        id_q   <= bus.ARID;
        addr_q <= bus.ARADDR[SRAM_AW+1:2];
        len_q  <= bus.ARLEN;
        beat_q <= '0;
`ifdef AXI_SRAM_ERRCHK_EN
        err_q  <= (bus.ARBURST != 2'b01);
`endif
      end
      if (w_hs || r_hs) begin
        addr_q <= addr_q + 1'b1;
        beat_q <= beat_q + 1'b1;
      end
`ifdef AXI_SRAM_ERRCHK_EN
      // beat_q counts beats before this one, so a correct WLAST sees beat_q == AWLEN.
      if (w_hs && bus.WLAST && (beat_q != {1'b0, len_q})) err_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: directed bursts, behavioural SRAM, and a
// scoreboard monitor comparing B and R channel traffic against queued
// expectations.
module tb_axi_sram_slave;

`ifdef AXI_SRAM_ERRCHK_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif
  localparam logic [1:0] INCR = 2'b01;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_cs;
  logic        sram_oe;
  logic [3:0]  sram_web;
  logic [13:0] sram_a;
  logic [31:0] sram_di;
  logic [31:0] sram_do;

  axi_sram_slave_if #(.IDW(8)) bus ();

  axi_sram_slave #(.IDW(8), .SRAM_AW(14)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sram_cs  (sram_cs),
    .sram_oe  (sram_oe),
    .sram_web (sram_web),
    .sram_a   (sram_a),
    .sram_di  (sram_di),
    .sram_do  (sram_do)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: byte-masked write, registered read.
  logic [31:0] mem [0:16383];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] di,
                                        input logic [3:0] web);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (!web[b]) r[8*b +: 8] = di[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_web != 4'hF) mem[sram_a] <= merge(mem[sram_a], sram_di, sram_web);
      sram_do <= mem[sram_a];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0]  id;
    logic [1:0]  resp;
  } bexp_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  bexp_t bq[$];
  rexp_t rq[$];

  // Scoreboard monitor: compares every presented R beat (also while stalled) and every B handshake.
  always @(negedge clk) begin
    bexp_t be;
    rexp_t re;
    if (!rst && bus.BVALID && bus.BREADY) begin
      if (bq.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        be = bq.pop_front();
        chk("bid", bus.BID, be.id);
        chk("bresp", bus.BRESP, be.resp);
      end
    end
    if (!rst && bus.RVALID) begin
      if (rq.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        re = rq[0];
        chk("rid", bus.RID, re.id);
        chk("rdata", bus.RDATA, re.data);
        chk("rresp", bus.RRESP, re.resp);
        chk("rlast", bus.RLAST, re.last);
        if (bus.RREADY) void'(rq.pop_front());
      end
    end
  end

  logic ar_watch = 1'b0;
  logic ar_seen  = 1'b0;

  always @(negedge clk) begin
    if (ar_watch && bus.ARREADY) ar_seen <= 1'b1;
  end

  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic aw_phase(input logic [7:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst);
    int t = 0;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = 3'd2;
    bus.AWBURST = burst; bus.AWVALID = 1'b1;
    @(negedge clk);
    while (!bus.AWREADY && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("aw_timeout", 1, 0);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
  endtask

  // n beats from wd/ws; WLAST on the last one.
  task automatic w_phase(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      bus.WDATA = wd[i]; bus.WSTRB = ws[i]; bus.WLAST = (i == n - 1); bus.WVALID = 1'b1;
      @(negedge clk);
      while (!bus.WREADY && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("w_timeout", 1, 0);
      @(posedge clk); #1;
    end
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
  endtask

  // Holds BREADY low for 'stall' cycles, then accepts; returns cycles BVALID was seen.
  task automatic b_phase(input int stall, output int hold);
    int t = 0;
    hold = 0;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (bus.BVALID) hold++;
      @(posedge clk); #1;
    end
    bus.BREADY = 1'b1;
    @(negedge clk);
    while (!bus.BVALID && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("b_timeout", 1, 0);
    else hold++;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
  endtask

  task automatic ar_phase(input logic [7:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst, output int waited);
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = 3'd2;
    bus.ARBURST = burst; bus.ARVALID = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus.ARREADY && waited < 50) begin @(negedge clk); waited++; end
    if (waited >= 50) chk("ar_timeout", 1, 0);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
  endtask

  // Accepts n beats, RREADY either held high or toggling 1/0; returns cycles used.
  task automatic r_phase(input int n, input bit toggle, output int cycles);
    int  got = 0;
    bit  rr  = 1'b1;
    cycles = 0;
    while (got < n && cycles < 100) begin
      bus.RREADY = toggle ? rr : 1'b1;
      @(negedge clk);
      if (cycles == 0) chk("first_rvalid", bus.RVALID, 1);
      if (bus.RVALID && bus.RREADY) got++;
      cycles++;
      rr = !rr;
      @(posedge clk); #1;
    end
    bus.RREADY = 1'b0;
    if (got < n) chk("r_timeout", 1, 0);
  endtask

  task automatic push_r(input logic [7:0] id, input int n, input logic [1:0] resp);
    for (int i = 0; i < n; i++) rq.push_back('{id: id, data: wd[i], resp: resp, last: (i == n - 1)});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hold;
    int cyc;
    int waited;

    rst = 1'b1;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;

    // Reset: everything quiet, write enables inactive.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", bus.AWREADY, 0);
    chk("rst_arready", bus.ARREADY, 0);
    chk("rst_wready",  bus.WREADY, 0);
    chk("rst_bvalid",  bus.BVALID, 0);
    chk("rst_rvalid",  bus.RVALID, 0);
    chk("rst_cs",      sram_cs, 0);
    chk("rst_oe",      sram_oe, 0);
    chk("rst_web",     sram_web, 4'hF);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_awready", bus.AWREADY, 1);
    chk("idle_arready", bus.ARREADY, 1);
    chk("idle_cs",      sram_cs, 0);
    @(posedge clk); #1;

    // 4-beat write to 0x100, B stalled two cycles.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
    bq.push_back('{id: 8'h5A, resp: 2'b00});
    aw_phase(8'h5A, 32'h100, 4'd3, INCR);
    w_phase(4);
    b_phase(2, hold);
    chk("bvalid_hold", hold, 3);
    for (int i = 0; i < 4; i++) chk("mem_wr4", mem[14'h40 + i], 32'hA0 + i);

    // Read back with RREADY toggling.
    push_r(8'h3C, 4, 2'b00);
    ar_phase(8'h3C, 32'h100, 4'd3, INCR, waited);
    r_phase(4, 1'b1, cyc);
    chk("rd4_toggle_cycles", cyc, 7);

    // Partial strobe over a full word.
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    bq.push_back('{id: 8'h01, resp: 2'b00});
    aw_phase(8'h01, 32'h40, 4'd0, INCR);
    w_phase(1);
    b_phase(0, hold);
    wd[0] = 32'h0000_0000; ws[0] = 4'b0101;
    bq.push_back('{id: 8'h02, resp: 2'b00});
    aw_phase(8'h02, 32'h40, 4'd0, INCR);
    w_phase(1);
    b_phase(0, hold);
    chk("mem_partial", mem[14'h10], 32'hFF00_FF00);
    wd[0] = 32'hFF00_FF00;
    push_r(8'h03, 1, 2'b00);
    ar_phase(8'h03, 32'h40, 4'd0, INCR, waited);
    r_phase(1, 1'b0, cyc);

    // AW and AR together: write wins, AR waits until after B.
    bus.ARID = 8'h22; bus.ARADDR = 32'h200; bus.ARLEN = 4'd1; bus.ARSIZE = 3'd2;
    bus.ARBURST = INCR; bus.ARVALID = 1'b1;
    ar_seen  = 1'b0;
    ar_watch = 1'b1;
    wd[0] = 32'h1111_0001; wd[1] = 32'h1111_0002; ws[0] = 4'hF; ws[1] = 4'hF;
    bq.push_back('{id: 8'h11, resp: 2'b00});
    aw_phase(8'h11, 32'h200, 4'd1, INCR);
    w_phase(2);
    b_phase(0, hold);
    ar_watch = 1'b0;
    chk("bvalid_nostall", hold, 1);
    chk("ar_blocked_while_busy", ar_seen, 0);
    push_r(8'h22, 2, 2'b00);
    ar_phase(8'h22, 32'h200, 4'd1, INCR, waited);
    chk("ar_after_b", waited, 0);
    r_phase(2, 1'b0, cyc);
    chk("rd2_cycles", cyc, 2);

    // Address wrap from word 16383 to word 0.
    wd[0] = 32'hDEAD_0001; wd[1] = 32'hDEAD_0002; ws[0] = 4'hF; ws[1] = 4'hF;
    bq.push_back('{id: 8'h44, resp: 2'b00});
    aw_phase(8'h44, 32'h0000_FFFC, 4'd1, INCR);
    w_phase(2);
    b_phase(1, hold);
    chk("mem_top", mem[14'h3FFF], 32'hDEAD_0001);
    chk("mem_wrap", mem[14'h0000], 32'hDEAD_0002);
    push_r(8'h45, 2, 2'b00);
    ar_phase(8'h45, 32'h0000_FFFC, 4'd1, INCR, waited);
    r_phase(2, 1'b0, cyc);

    // Short write burst (WLAST on beat 2 of 4) and a FIXED read burst.
    wd[0] = 32'h0BAD_0000; wd[1] = 32'h0BAD_0001; ws[0] = 4'hF; ws[1] = 4'hF;
    bq.push_back('{id: 8'h66, resp: ERR_RESP});
    aw_phase(8'h66, 32'h300, 4'd3, INCR);
    w_phase(2);
    b_phase(0, hold);
    chk("mem_short0", mem[14'hC0], 32'h0BAD_0000);
    chk("mem_short1", mem[14'hC1], 32'h0BAD_0001);
    push_r(8'h67, 2, ERR_RESP);
    ar_phase(8'h67, 32'h300, 4'd1, 2'b00, waited);
    r_phase(2, 1'b0, cyc);

    repeat (2) @(posedge clk);
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
